array_heap: RTL and testbench
=============================

# array_heap

Parametrised heap memory unit servicing array allocate, free, indexed write/read and size queries through a single valid/ready request port with registered responses. It is the next-generation hardware form of the array/heap machinery used by the generated `fpga` test programs. It generalises element width, array count and area size, and adds:
- an allocated-array bitmap;
- zero-fill on allocate;
- per-request error reporting;
- usage counters.

## Interface
Parameters:
- `MemoryElementWidth`, 12: width of every heap element and data bus.
- `NArea`, 4: elements per array area; power of two, at least 2.
- `NArrays`, 4: maximum simultaneous arrays; power of two, at least 2.
- `AW`, `$clog2(NArrays)`: array handle width (derived).
- `IW`, `$clog2(NArea)+1`: index width; the extra bit allows out-of-range indices to be expressed (derived).

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_op` in 3: 0 ALLOC, 1 FREE, 2 WRITE, 3 READ, 4 SIZE, 5 CLEAR; 6–7 are illegal.
- `req_array` in AW: target array handle (ignored by ALLOC).
- `req_index` in IW: element index (WRITE/READ only).
- `req_data` in MemoryElementWidth: write data.
- `resp_valid` out 1: one-cycle pulse carrying the result of exactly one accepted request.
- `resp_data` out MemoryElementWidth: ALLOC handle, READ value or SIZE; 0 otherwise and on error.
- `resp_error` out 1: request rejected; no state was changed.
- `in_use` out AW+1: number of live arrays.
- `high_water` out AW+1: count of fresh (never previously issued) handles handed out.

## Operation
- Storage:
  - `heap[NArrays*NArea]`: element of array a, index i lives at a*NArea+i.
  - `sizes[NArrays]`.
  - `live[NArrays]` bitmap.
  - `freed[NArrays]` LIFO stack with `freedTop`.
- A request is accepted when `req_valid && req_ready`.
- ALLOC:
  - Handle source: if `freedTop>0`, pop the stack (most recently freed handle first). Otherwise, if `high_water<NArrays`, take handle `high_water` and increment `high_water`.
  - If neither source is available, respond with error.
  - On success: set `live`, set `sizes`=0, increment `in_use`, then zero the area one element per cycle (state CLEAR_AREA).
- FREE:
  - Error if the array is not live.
  - Otherwise clear `live`, push the handle onto `freed`, decrement `in_use`.
  - Heap contents are left untouched.
- WRITE:
  - Error if the array is not live or `req_index>=NArea`.
  - Otherwise `heap[a*NArea+i]=req_data` and `sizes[a]=max(sizes[a],i+1)`.
- READ:
  - Error if the array is not live or `req_index>=sizes[a]`.
  - Otherwise return the element.
- SIZE: error if the array is not live; otherwise return `sizes[a]`.
- CLEAR: error if the array is not live; otherwise set `sizes[a]`=0. Contents are retained but unreadable until rewritten.
- Illegal op (6–7): error, no state change.
- Arithmetic: `sizes` width is IW, and `sizes` never exceeds NArea. Counters saturate logically at NArrays by construction and never wrap.
- State machine:
  - IDLE to RESP on any accepted non-ALLOC request, or on an ALLOC that errors.
  - IDLE to CLEAR_AREA on a successful ALLOC.
  - CLEAR_AREA holds a counter 0..NArea-1 and moves to RESP after writing the element at index NArea-1.
  - RESP returns to IDLE.

## Timing
- Reset values: `req_ready`=0 during the reset cycle and 1 in the first cycle after reset. `resp_valid`=0, `resp_data`=0, `resp_error`=0, `in_use`=0, `high_water`=0. `freedTop`=0, all `live`=0, all `sizes`=0. Heap contents are not reset.
- Non-ALLOC requests and failed ALLOCs: accepted at cycle T, response at T+1, `req_ready` back high at T+2. Throughput is one request per 2 cycles.
- Successful ALLOC: accepted at T, area zeroed over cycles T+1..T+NArea, response at T+NArea+1. `req_ready`=0 from T+1 until the response cycle inclusive.
- `req_ready` is low in CLEAR_AREA and RESP. Requests presented while it is low are not consumed and must be held by the requester.
- `resp_valid` is high for exactly one cycle per accepted request. `resp_data` and `resp_error` are valid only while `resp_valid`=1 and read 0 otherwise.
- `in_use` and `high_water` update in the cycle after acceptance and are visible no later than the response.
- Reset in any state, including mid CLEAR_AREA, aborts the operation. No response is issued, and the full reset state applies next cycle.
- A freed handle re-issued by ALLOC is fully zeroed before its response, so a stale value is never readable.

## Test plan
- Basic sequence:
  - ALLOC→handle 0; WRITE 0[0]=11; WRITE 0[1]=22; ALLOC→handle 1; WRITE 1[1]=33.
  - READ 0[0]=11, READ 0[1]=22, READ 1[1]=33; SIZE 1=2.
  - `in_use`=2, `high_water`=2, and no response has `resp_error` set.
- Reuse and zero-fill: FREE 0, then ALLOC→0. SIZE 0=0; WRITE 0[2]=5; READ 0[0]=0 and READ 0[2]=5; SIZE 0=3. `high_water` stays 2.
- Exhaustion and LIFO: ALLOC four times→0,1,2,3; a fifth ALLOC errors with `resp_data`=0. FREE 2 then FREE 1; the next ALLOCs return 1 then 2.
- Error cases, each followed by a SIZE check showing no state change:
  - WRITE at index 4 errors.
  - READ beyond size errors.
  - A second FREE of the same handle errors.
  - Op 7 errors.
  - An op on a non-live handle errors.
- Timing: a successful ALLOC produces its response exactly NArea+1=5 cycles after acceptance with `req_ready` low throughout. A held `req_valid` is not consumed while `req_ready` is low.
- Reset mid-clear: assert `reset` during CLEAR_AREA. No `resp_valid` follows, `in_use`=0, and the next ALLOC returns handle 0.

Source files
------------

// File: rtl/array_heap_if.sv
// Request/response port of the array heap: one valid/ready request channel
// and a registered single-cycle response pulse.
interface array_heap_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 4
);
  localparam int AW = $clog2(NArrays);
  localparam int IW = $clog2(NArea) + 1;

  logic                          req_valid;
  logic                          req_ready;
  logic [2:0]                    req_op;
  logic [AW-1:0]                 req_array;
  logic [IW-1:0]                 req_index;
  logic [MemoryElementWidth-1:0] req_data;
  logic                          resp_valid;
  logic [MemoryElementWidth-1:0] resp_data;
  logic                          resp_error;

  modport master (
    output req_valid, req_op, req_array, req_index, req_data,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_op, req_array, req_index, req_data,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/array_heap.sv
// Heap of fixed-size array areas: allocate (with zero-fill), free (LIFO reuse),
// indexed write/read, size query and clear, one request in flight at a time.
module array_heap #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 4,
  localparam int AW = $clog2(NArrays),
  localparam int IW = $clog2(NArea) + 1
) (
  input  logic          clock,
  input  logic          reset,
  array_heap_if.slave   bus,
  output logic [AW:0]   in_use,
  output logic [AW:0]   high_water
);

  localparam int W  = MemoryElementWidth;
  localparam int HW = AW + IW - 1;   // heap address width: {handle, index}

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR_AREA,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_ALLOC = 3'd0,
    OP_FREE  = 3'd1,
    OP_WRITE = 3'd2,
    OP_READ  = 3'd3,
    OP_SIZE  = 3'd4,
    OP_CLEAR = 3'd5
  } op_t;

  state_t state_q, state_d;

  logic [W-1:0]    heap [NArrays*NArea];
  logic [IW-1:0]   sizes [NArrays];
  logic [NArrays-1:0] live;
  logic [AW-1:0]   freed [NArrays];
  logic [AW:0]     freed_top;

  logic [AW-1:0]   clr_array_q;
  logic [IW-2:0]   clr_cnt_q;
  logic [W-1:0]    resp_data_q;
  logic            resp_error_q;

  // Request decode
  logic            ready;
  logic            accept;
  logic [AW-1:0]   arr;
  logic [IW-1:0]   idx;
  logic [HW-1:0]   elem_addr;
  logic            arr_live;
  logic            alloc_from_stack;
  logic            alloc_fresh;
  logic [AW-1:0]   alloc_handle;
  logic            op_error;
  logic [W-1:0]    op_result;
  logic            clear_last;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    accept           = bus.req_valid && ready;
    arr              = bus.req_array;
    idx              = bus.req_index;
    elem_addr        = {arr, idx[IW-2:0]};
    arr_live         = live[arr];
    alloc_from_stack = (freed_top != '0);
    alloc_fresh      = (high_water < (AW+1)'(NArrays));
    alloc_handle     = alloc_from_stack ? freed[AW'(freed_top - 1'b1)]
                                        : high_water[AW-1:0];
    clear_last       = (clr_cnt_q == (IW-1)'(NArea - 1));
    op_error         = 1'b1;
    op_result        = '0;
    case (bus.req_op)
      OP_ALLOC: begin
        op_error  = !(alloc_from_stack || alloc_fresh);
        op_result = W'(alloc_handle);
      end
      OP_FREE:  op_error = !arr_live;
      OP_WRITE: op_error = !arr_live || (idx >= IW'(NArea));
      OP_READ: begin
        op_error  = !arr_live || (idx >= sizes[arr]);
        op_result = heap[elem_addr];
      end
      OP_SIZE: begin
        op_error  = !arr_live;
        op_result = W'(sizes[arr]);
      end
      OP_CLEAR: op_error = !arr_live;
      default:  op_error = 1'b1;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking <= so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.req_op == OP_ALLOC && !op_error) state_d = S_CLEAR_AREA;
          else                                     state_d = S_RESP;
        end
      end
      S_CLEAR_AREA: if (clear_last) state_d = S_RESP;
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Response fields read as zero outside the response cycle.
  always_comb begin
    ready          = (state_q == S_IDLE) && !reset;
    bus.req_ready  = ready;
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_data  = (state_q == S_RESP) ? resp_data_q : '0;
    bus.resp_error = (state_q == S_RESP) && resp_error_q;
  end

  // Bookkeeping: bitmap, sizes, free stack pointer, counters, response latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      live         <= '0;
      freed_top    <= '0;
      in_use       <= '0;
      high_water   <= '0;
      clr_array_q  <= '0;
      clr_cnt_q    <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      for (int k = 0; k < NArrays; k++) sizes[k] <= '0;
    end else begin
      if (accept) begin
        resp_data_q  <= op_error ? '0 : op_result;
        resp_error_q <= op_error;
      end
      if (accept && !op_error) begin
        case (bus.req_op)
          OP_ALLOC: begin
            live[alloc_handle]  <= 1'b1;
            sizes[alloc_handle] <= '0;
            in_use              <= in_use + 1'b1;
            if (alloc_from_stack) freed_top  <= freed_top - 1'b1;
            else                  high_water <= high_water + 1'b1;
            clr_array_q <= alloc_handle;
            clr_cnt_q   <= '0;
          end
          OP_FREE: begin
            live[arr] <= 1'b0;
            freed_top <= freed_top + 1'b1;
            in_use    <= in_use - 1'b1;
          end
          OP_WRITE: begin
            if ((idx + IW'(1)) > sizes[arr]) sizes[arr] <= idx + IW'(1);
          end
          OP_CLEAR: sizes[arr] <= '0;
          default: ;
        endcase
      end
      if (state_q == S_CLEAR_AREA) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // NOTE: heap and free-stack storage carry no reset; a live bit or the stack
  // pointer guards every read, and allocation zero-fills the area.
  always_ff @(posedge clock) begin
    if (accept && !op_error && bus.req_op == OP_WRITE)
      heap[elem_addr] <= bus.req_data;
    else if (state_q == S_CLEAR_AREA)
      heap[{clr_array_q, clr_cnt_q}] <= '0;
    if (accept && !op_error && bus.req_op == OP_FREE)
      freed[freed_top[AW-1:0]] <= arr;
  end

endmodule

// File: tb/tb_array_heap.sv
// Self-checking bench for array_heap: directed plan plus random requests
// compared against a queue/array reference model of the heap.
module tb_array_heap;
  localparam int W     = 12;
  localparam int NAREA = 4;
  localparam int NARR  = 4;
  localparam int AW    = 2;
  localparam int IW    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AW:0] in_use, high_water;

  array_heap_if #(.MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR)) bus ();

  array_heap #(.MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .in_use     (in_use),
    .high_water (high_water)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  bit live_m [NARR];
  int size_m [NARR];
  int heap_m [NARR][NAREA];
  int freed_m [$];
  int hw_m, in_use_m;

  task automatic model_reset();
    for (int a = 0; a < NARR; a++) begin
      live_m[a] = 0;
      size_m[a] = 0;
    end
    freed_m.delete();
    hw_m     = 0;
    in_use_m = 0;
  endtask

  task automatic model_apply(input int op, input int a, input int i, input int d,
                             output int ed, output bit ee, output int el);
    int h;
    ed = 0; ee = 1; el = 1;
    case (op)
      0: if (freed_m.size() > 0 || hw_m < NARR) begin
           if (freed_m.size() > 0) h = freed_m.pop_back();
           else begin h = hw_m; hw_m++; end
           live_m[h] = 1;
           size_m[h] = 0;
           for (int k = 0; k < NAREA; k++) heap_m[h][k] = 0;
           in_use_m++;
           ed = h; ee = 0; el = NAREA + 1;
         end
      1: if (live_m[a]) begin
           live_m[a] = 0;
           freed_m.push_back(a);
           in_use_m--;
           ee = 0;
         end
      2: if (live_m[a] && i < NAREA) begin
           heap_m[a][i] = d;
           if (i + 1 > size_m[a]) size_m[a] = i + 1;
           ee = 0;
         end
      3: if (live_m[a] && i < size_m[a]) begin
           ed = heap_m[a][i]; ee = 0;
         end
      4: if (live_m[a]) begin ed = size_m[a]; ee = 0; end
      5: if (live_m[a]) begin size_m[a] = 0; ee = 0; end
      default: ;
    endcase
  endtask

  task automatic drive(input int op, input int a, input int i, input int d);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'(op);
    bus.req_array = AW'(a);
    bus.req_index = IW'(i);
    bus.req_data  = W'(d);
  endtask

  // One request: wait for ready, measure latency, compare with the model.
  task automatic req(input int op, input int a, input int i, input int d,
                     output int got_d, output bit got_e);
    int ed, el, wait_n, lat;
    bit ee, rdy_high;
    model_apply(op, a, i, d, ed, ee, el);
    @(negedge clock);
    drive(op, a, i, d);
    wait_n = 0;
    while (!bus.req_ready && wait_n < 50) begin
      @(negedge clock);
      wait_n++;
    end
    check("accept_wait", 32'(wait_n < 50), 1);
    @(negedge clock);
    bus.req_valid = 1'b0;
    lat = 1; rdy_high = 0;
    while (!bus.resp_valid && lat < 50) begin
      if (bus.req_ready) rdy_high = 1;
      @(negedge clock);
      lat++;
    end
    if (bus.req_ready) rdy_high = 1;
    got_d = int'(bus.resp_data);
    got_e = bus.resp_error;
    check($sformatf("op%0d_latency", op), lat, el);
    check($sformatf("op%0d_data", op), got_d, ed);
    check($sformatf("op%0d_error", op), 32'(got_e), 32'(ee));
    check($sformatf("op%0d_ready_low", op), 32'(rdy_high), 0);
    check("in_use", 32'(in_use), in_use_m);
    check("high_water", 32'(high_water), hw_m);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_ready_low", 32'(bus.req_ready), 0);
    reset = 1'b0;
    model_reset();
  endtask

  int  rd;
  bit  re;
  int  pulses, first_lat, d1, d2, ed, el;
  bit  ee, drop;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_array = '0;
    bus.req_index = '0;
    bus.req_data  = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready_after", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_data", 32'(bus.resp_data), 0);
    check("rst_resp_error", 32'(bus.resp_error), 0);
    check("rst_in_use", 32'(in_use), 0);
    check("rst_high_water", 32'(high_water), 0);

    // Basic sequence
    req(0, 0, 0, 0, rd, re);  check("basic_alloc0", rd, 0);
    req(2, 0, 0, 11, rd, re);
    req(2, 0, 1, 22, rd, re);
    req(0, 0, 0, 0, rd, re);  check("basic_alloc1", rd, 1);
    req(2, 1, 1, 33, rd, re);
    req(3, 0, 0, 0, rd, re);  check("basic_rd00", rd, 11);
    req(3, 0, 1, 0, rd, re);  check("basic_rd01", rd, 22);
    req(3, 1, 1, 0, rd, re);  check("basic_rd11", rd, 33);
    req(4, 1, 0, 0, rd, re);  check("basic_size1", rd, 2);
    check("basic_in_use", 32'(in_use), 2);
    check("basic_hw", 32'(high_water), 2);

    // Reuse and zero-fill
    req(1, 0, 0, 0, rd, re);
    req(0, 0, 0, 0, rd, re);  check("reuse_alloc", rd, 0);
    req(4, 0, 0, 0, rd, re);  check("reuse_size0", rd, 0);
    req(2, 0, 2, 5, rd, re);
    req(3, 0, 0, 0, rd, re);  check("reuse_rd0", rd, 0);  check("reuse_rd0_err", 32'(re), 0);
    req(3, 0, 2, 0, rd, re);  check("reuse_rd2", rd, 5);
    req(4, 0, 0, 0, rd, re);  check("reuse_size3", rd, 3);
    check("reuse_hw", 32'(high_water), 2);

    // Exhaustion and LIFO reuse
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req(0, 0, 0, 0, rd, re);
      check("exh_alloc", rd, k);
    end
    req(0, 0, 0, 0, rd, re);  check("exh_err", 32'(re), 1);  check("exh_data", rd, 0);
    req(1, 2, 0, 0, rd, re);
    req(1, 1, 0, 0, rd, re);
    req(0, 0, 0, 0, rd, re);  check("lifo_first", rd, 1);
    req(0, 0, 0, 0, rd, re);  check("lifo_second", rd, 2);

    // Error cases, each followed by a size check
    req(2, 0, 1, 7, rd, re);
    req(2, 0, 4, 9, rd, re);  check("err_wr_idx4", 32'(re), 1);
    req(4, 0, 0, 0, rd, re);  check("err_wr_size", rd, 2);
    req(3, 0, 2, 0, rd, re);  check("err_rd_beyond", 32'(re), 1);
    req(4, 0, 0, 0, rd, re);  check("err_rd_size", rd, 2);
    req(1, 3, 0, 0, rd, re);
    req(1, 3, 0, 0, rd, re);  check("err_double_free", 32'(re), 1);
    req(4, 0, 0, 0, rd, re);  check("err_df_size", rd, 2);
    req(7, 0, 0, 0, rd, re);  check("err_op7", 32'(re), 1);
    req(4, 0, 0, 0, rd, re);  check("err_op7_size", rd, 2);
    req(2, 3, 0, 1, rd, re);  check("err_nonlive", 32'(re), 1);
    req(4, 3, 0, 0, rd, re);  check("err_nonlive_size", 32'(re), 1);

    // Held request during an allocation is not consumed early
    model_apply(0, 0, 0, 0, ed, ee, el);
    d1 = ed;
    model_apply(4, d1, 0, 0, ed, ee, el);
    d2 = ed;
    @(negedge clock);
    drive(0, 0, 0, 0);
    while (!bus.req_ready) @(negedge clock);
    @(negedge clock);
    drive(4, d1, 0, 0);
    pulses = 0; first_lat = 0; drop = 0; ed = -1; el = -1;
    for (int c = 0; c < 20; c++) begin
      if (drop) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        pulses++;
        if (pulses == 1) begin first_lat = c + 1; ed = int'(bus.resp_data); end
        else el = int'(bus.resp_data);
      end
      if (bus.req_valid && bus.req_ready) drop = 1;
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    check("held_pulses", pulses, 2);
    check("held_alloc_latency", first_lat, NAREA + 1);
    check("held_alloc_handle", ed, d1);
    check("held_size", el, d2);

    // Reset during CLEAR_AREA
    @(negedge clock);
    drive(1, 0, 0, 0);
    while (!bus.req_ready) @(negedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    drive(0, 0, 0, 0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.resp_valid) pulses++;
      @(negedge clock);
    end
    check("midclr_no_resp", pulses, 0);
    check("midclr_in_use", 32'(in_use), 0);
    req(0, 0, 0, 0, rd, re);  check("midclr_alloc0", rd, 0);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      int r, op;
      r = $urandom_range(0, 15);
      if      (r <= 2)  op = 0;
      else if (r <= 4)  op = 1;
      else if (r <= 8)  op = 2;
      else if (r <= 11) op = 3;
      else if (r == 12) op = 4;
      else if (r == 13) op = 5;
      else              op = 6 + (r - 14);
      req(op, $urandom_range(0, NARR - 1), $urandom_range(0, 5),
          $urandom_range(0, (1 << W) - 1), rd, re);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
